// File: rtl/stereo_pkg.sv
// Shared types and default geometry for the stereo window feeder and its disparity engine.
// Defaults describe the full-size engine; blocks take them as parameter defaults.
package stereo_pkg;

  localparam int WIN_DEF       = 15;
  localparam int DATA_SIZE_DEF = 8;
  localparam int IMG_W_DEF     = 64;
  localparam int MAX_DISP_DEF  = 64;
  localparam int TIMEOUT_DEF   = 4096;

  localparam int DISP_BITS = $clog2(MAX_DISP_DEF);
  localparam int SAD_BITS  = DATA_SIZE_DEF + $clog2(WIN_DEF * WIN_DEF);
  localparam int IMG_W_ARR = DATA_SIZE_DEF * IMG_W_DEF * WIN_DEF;

  typedef enum logic [2:0] {FILL, CLEAR, ISSUE, WAIT, EMIT} feeder_state_e;

  function automatic int arr_bits(input int data_size, input int img_w, input int win);
    return data_size * img_w * win;
  endfunction

endpackage

// File: rtl/stereo_window_feeder_if.sv
// Pixel-in, engine request and result-out signals of the feeder; master is the feeder side.
// slave is the environment (pixel source, engine, result sink).
interface stereo_window_feeder_if
  import stereo_pkg::*;
#(
  parameter int WIN       = WIN_DEF,
  parameter int IMG_W     = IMG_W_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DISP_BITS = $clog2(MAX_DISP_DEF)
);
  localparam int CW = $clog2(IMG_W);
  localparam int AW = arr_bits(DATA_SIZE, IMG_W, WIN);

  logic                 s_valid;
  logic                 s_ready;
  logic                 s_sof;
  logic [DATA_SIZE-1:0] s_pix_l;
  logic [DATA_SIZE-1:0] s_pix_r;
  logic [AW-1:0]        eng_array_l;
  logic [AW-1:0]        eng_array_r;
  logic                 eng_ready;
  logic [CW-1:0]        eng_col;
  logic                 eng_rst;
  logic                 eng_done;
  logic [DISP_BITS-1:0] eng_disp;
  logic                 m_valid;
  logic                 m_ready;
  logic [DISP_BITS-1:0] m_disp;
  logic [CW-1:0]        m_col;
  logic                 m_last;
  logic                 err;

  modport master (
    input  s_valid, s_sof, s_pix_l, s_pix_r, eng_done, eng_disp, m_ready,
    output s_ready, eng_array_l, eng_array_r, eng_ready, eng_col, eng_rst,
           m_valid, m_disp, m_col, m_last, err
  );

  modport slave (
    output s_valid, s_sof, s_pix_l, s_pix_r, eng_done, eng_disp, m_ready,
    input  s_ready, eng_array_l, eng_array_r, eng_ready, eng_col, eng_rst,
           m_valid, m_disp, m_col, m_last, err
  );

endinterface

// File: rtl/window_shift_buf.sv
// WIN-row pixel shift register: new pixel enters the top entry, entry 0 holds the oldest pixel.
// One-cycle write latency; shifts only when shift_en is high, no backpressure of its own.
module window_shift_buf #(
  parameter int WIN       = 15,
  parameter int IMG_W     = 64,
  parameter int DATA_SIZE = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             shift_en,
  input  logic [DATA_SIZE-1:0]             pix_in,
  output logic [DATA_SIZE*IMG_W*WIN-1:0]   packed_out
);
  localparam int AW = DATA_SIZE * IMG_W * WIN;

  logic [AW-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (shift_en) begin
      shreg <= {pix_in, shreg[AW-1:DATA_SIZE]};
    end
  end

  assign packed_out = shreg;

endmodule

// File: rtl/stereo_window_feeder.sv
// Buffers WIN raster rows, then sweeps the disparity engine across every valid column of the window.
// Per column: CLEAR, ISSUE, engine cycles, capture; result held on m_valid until m_ready, stalling the sweep.
module stereo_window_feeder
  import stereo_pkg::*;
#(
  parameter int WIN       = WIN_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int IMG_W     = IMG_W_DEF,
  parameter int MAX_DISP  = MAX_DISP_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stereo_window_feeder_if.master bus
);
  localparam int DW = $clog2(MAX_DISP);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(WIN + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int AW = arr_bits(DATA_SIZE, IMG_W, WIN);

  localparam logic [CW-1:0] LAST_PIX  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - WIN);
  localparam logic [RW-1:0] FULL_ROWS = RW'(WIN);
  // Counter starts at 0 the cycle after the strobe, so this lands err TIMEOUT cycles after it.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 2);

  feeder_state_e   state;
  logic [CW-1:0]   col;
  logic [CW-1:0]   pix_cnt;
  logic [RW-1:0]   rows_filled;
  logic [TW-1:0]   wait_cnt;
  logic            s_ready_q, eng_ready_q, eng_rst_q;
  logic            m_valid_q, m_last_q, err_q;
  logic [DW-1:0]   m_disp_q;
  logic [CW-1:0]   m_col_q;
  logic [AW-1:0]   arr_l, arr_r;

  logic            accept;
  logic [CW-1:0]   eff_col;
  logic [RW-1:0]   eff_rows;
  logic [RW-1:0]   rows_inc;

  // s_ready_q is only ever high in FILL, so accept needs no state qualifier.
  assign accept   = bus.s_valid & s_ready_q;
  assign eff_col  = bus.s_sof ? '0 : pix_cnt;
  assign eff_rows = bus.s_sof ? '0 : rows_filled;
  assign rows_inc = (eff_rows == FULL_ROWS) ? FULL_ROWS : eff_rows + RW'(1);

  window_shift_buf #(.WIN(WIN), .IMG_W(IMG_W), .DATA_SIZE(DATA_SIZE)) u_buf_l (
    .clk(clk), .rst_n(rst_n), .shift_en(accept), .pix_in(bus.s_pix_l), .packed_out(arr_l)
  );
  window_shift_buf #(.WIN(WIN), .IMG_W(IMG_W), .DATA_SIZE(DATA_SIZE)) u_buf_r (
    .clk(clk), .rst_n(rst_n), .shift_en(accept), .pix_in(bus.s_pix_r), .packed_out(arr_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      col         <= '0;
      pix_cnt     <= '0;
      rows_filled <= '0;
      wait_cnt    <= '0;
      s_ready_q   <= 1'b0;
      eng_ready_q <= 1'b0;
      eng_rst_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_disp_q    <= '0;
      m_col_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          eng_rst_q <= 1'b0;
          s_ready_q <= 1'b1;
          if (accept) begin
            if (eff_col == LAST_PIX) begin
              pix_cnt     <= '0;
              rows_filled <= rows_inc;
              if (rows_inc == FULL_ROWS) begin
                state     <= CLEAR;
                eng_rst_q <= 1'b1;
                s_ready_q <= 1'b0;
                col       <= '0;
              end
            end else begin
              pix_cnt     <= eff_col + CW'(1);
              rows_filled <= eff_rows;
            end
          end
        end
        CLEAR: begin
          eng_rst_q   <= 1'b0;
          eng_ready_q <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          eng_ready_q <= 1'b0;
          wait_cnt    <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          if (bus.eng_done || wait_cnt == TMO_LAST) begin
            m_disp_q  <= bus.eng_done ? bus.eng_disp : '0;
            err_q     <= err_q | ~bus.eng_done;
            m_col_q   <= col;
            m_last_q  <= (col == LAST_COL);
            m_valid_q <= 1'b1;
            state     <= EMIT;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        EMIT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (m_last_q) begin
              col       <= '0;
              s_ready_q <= 1'b1;
              state     <= FILL;
            end else begin
              col       <= col + CW'(1);
              eng_rst_q <= 1'b1;
              state     <= CLEAR;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.eng_array_l = arr_l;
  assign bus.eng_array_r = arr_r;
  assign bus.eng_ready   = eng_ready_q;
  assign bus.eng_col     = col;
  assign bus.eng_rst     = eng_rst_q;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_disp      = m_disp_q;
  assign bus.m_col       = m_col_q;
  assign bus.m_last      = m_last_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_stereo_window_feeder.sv
// Bench for stereo_window_feeder: random pixel rows, an engine stub, and a window/result reference model.
module tb_stereo_window_feeder;
  localparam int WIN = 3, IMG_W = 8, DS = 8, MAX_DISP = 4, TIMEOUT = 32, DB = 2;
  localparam int NCOL = IMG_W - WIN + 1, NPIX = WIN * IMG_W, AW = DS * NPIX;
  localparam int STUB_LAT = 5, BOUND = 300;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stereo_window_feeder_if #(.WIN(WIN), .IMG_W(IMG_W), .DATA_SIZE(DS), .DISP_BITS(DB)) bus ();

  stereo_window_feeder #(.WIN(WIN), .DATA_SIZE(DS), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP),
                         .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Every accepted pixel in order; the window is always the newest NPIX of them.
  logic [DS-1:0] hist_l[$];
  logic [DS-1:0] hist_r[$];

  // Engine stub: answers disp = col % MAX_DISP STUB_LAT cycles after the strobe, holds done until cleared.
  logic       stub_en = 1'b1;
  logic       stub_busy;
  int         stub_cnt;
  logic [2:0] stub_col;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.eng_done <= 1'b0;
      bus.eng_disp <= '0;
      stub_busy    <= 1'b0;
      stub_cnt     <= 0;
      stub_col     <= '0;
    end else if (bus.eng_rst) begin
      bus.eng_done <= 1'b0;
      stub_busy    <= 1'b0;
    end else if (bus.eng_ready) begin
      stub_busy <= 1'b1;
      stub_cnt  <= STUB_LAT;
      stub_col  <= bus.eng_col;
    end else if (stub_busy && stub_en) begin
      if (stub_cnt <= 1) begin
        bus.eng_done <= 1'b1;
        bus.eng_disp <= DB'(int'(stub_col) % MAX_DISP);
        stub_busy    <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  int obs_col[NCOL], obs_disp[NCOL], obs_last[NCOL], obs_rstp[NCOL], obs_ecol[NCOL];
  logic [AW-1:0] obs_win_l, obs_win_r;
  int obs_err_lat, obs_hold_bad;

  task automatic hist_zero();
    hist_l.delete();
    hist_r.delete();
    for (int i = 0; i < NPIX; i++) begin
      hist_l.push_back('0);
      hist_r.push_back('0);
    end
  endtask

  function automatic logic [AW-1:0] model_win(input bit right);
    logic [AW-1:0] w;
    int base;
    w = '0;
    base = hist_l.size() - NPIX;
    for (int k = 0; k < NPIX; k++) w[k*DS +: DS] = right ? hist_r[base+k] : hist_l[base+k];
    return w;
  endfunction

  task automatic send_pix(input logic [DS-1:0] l, input logic [DS-1:0] r, input logic sof);
    int n;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_sof   = sof;
    bus.s_pix_l = l;
    bus.s_pix_r = r;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) begin
      tests++; fails++;
      $display("FAIL send_pix: s_ready=%b after %0d cycles, required 1", bus.s_ready, n);
    end else begin
      hist_l.push_back(l);
      hist_r.push_back(r);
    end
  endtask

  task automatic send_row(input bit sof, input bit idx_mode, input int base);
    for (int i = 0; i < IMG_W; i++)
      send_pix(idx_mode ? DS'(base + i) : DS'($urandom), DS'($urandom), sof && (i == 0));
  endtask

  task automatic end_stream();
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  // Drives one window row through the engine and records what the DUT showed for each column.
  task automatic run_row(input int hold_col, input int dead_col);
    int n;
    logic prev_rst, err0;
    obs_err_lat  = -1;
    obs_hold_bad = 0;
    for (int c = 0; c < NCOL; c++) begin
      prev_rst = 1'b0;
      n = 0;
      while (bus.eng_ready !== 1'b1 && n < BOUND) begin
        prev_rst = bus.eng_rst;
        @(negedge clk);
        n++;
      end
      if (n >= BOUND) begin
        tests++; fails++;
        $display("FAIL eng_ready_wait: col %0d eng_ready=%b, required 1 within %0d cycles", c, bus.eng_ready, BOUND);
        return;
      end
      obs_rstp[c] = prev_rst;
      obs_ecol[c] = int'(bus.eng_col);
      if (c == 0) begin
        obs_win_l = bus.eng_array_l;
        obs_win_r = bus.eng_array_r;
      end
      if (c == dead_col) stub_en = 1'b0;
      err0 = bus.err;
      @(negedge clk);
      n = 1;
      while (bus.m_valid !== 1'b1 && n < BOUND) begin
        if (!err0 && bus.err === 1'b1 && obs_err_lat < 0) obs_err_lat = n;
        @(negedge clk);
        n++;
      end
      if (!err0 && bus.err === 1'b1 && obs_err_lat < 0) obs_err_lat = n;
      stub_en = 1'b1;
      if (n >= BOUND) begin
        tests++; fails++;
        $display("FAIL m_valid_wait: col %0d m_valid=%b, required 1 within %0d cycles", c, bus.m_valid, BOUND);
        return;
      end
      obs_col[c]  = int'(bus.m_col);
      obs_disp[c] = int'(bus.m_disp);
      obs_last[c] = int'(bus.m_last);
      if (c == hold_col) begin
        repeat (20) begin
          @(negedge clk);
          if (bus.m_valid !== 1'b1 || int'(bus.m_col) != obs_col[c] ||
              int'(bus.m_disp) != obs_disp[c] || bus.eng_ready !== 1'b0) obs_hold_bad++;
        end
      end
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.s_ready, bus.eng_ready, bus.m_valid, bus.m_last, bus.err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 00000", {bus.s_ready, bus.eng_ready, bus.m_valid, bus.m_last, bus.err});
    end
    tests++;
    if (bus.eng_rst !== 1'b1) begin fails++; $display("FAIL reset_eng_rst: got %b, required 1", bus.eng_rst); end
    tests++;
    if ({bus.eng_col, bus.m_col, bus.m_disp} !== '0) begin
      fails++;
      $display("FAIL reset_fields: eng_col=%0d m_col=%0d m_disp=%0d, required 0", bus.eng_col, bus.m_col, bus.m_disp);
    end
    tests++;
    if ({bus.eng_array_l, bus.eng_array_r} !== '0) begin
      fails++; $display("FAIL reset_arrays: got %h, required 0", bus.eng_array_l);
    end
    rst_n = 1'b1;
    hist_zero();
    @(negedge clk);
    tests++;
    if (bus.s_ready !== 1'b1 || bus.eng_rst !== 1'b0) begin
      fails++; $display("FAIL fill_entry: s_ready=%b eng_rst=%b, required 1/0", bus.s_ready, bus.eng_rst);
    end
  endtask

  task automatic check_results(input string tag, input int dead_col);
    for (int c = 0; c < NCOL; c++) begin
      tests++;
      if (obs_col[c] != c || obs_ecol[c] != c) begin
        fails++; $display("FAIL %s_col: m_col=%0d eng_col=%0d, required %0d", tag, obs_col[c], obs_ecol[c], c);
      end
      tests++;
      if (obs_disp[c] != ((c == dead_col) ? 0 : c % MAX_DISP)) begin
        fails++; $display("FAIL %s_disp: col %0d got %0d, required %0d", tag, c, obs_disp[c],
                          (c == dead_col) ? 0 : c % MAX_DISP);
      end
      tests++;
      if (obs_last[c] != ((c == NCOL - 1) ? 1 : 0)) begin
        fails++; $display("FAIL %s_last: col %0d got %0d, required %0d", tag, c, obs_last[c], (c == NCOL - 1) ? 1 : 0);
      end
      tests++;
      if (obs_rstp[c] != 1) begin
        fails++; $display("FAIL %s_rst_pulse: col %0d eng_rst before eng_ready=%0d, required 1", tag, c, obs_rstp[c]);
      end
    end
  endtask

  task automatic test_fill_and_sweep();
    logic [AW-1:0] idx_win;
    for (int i = 0; i < NPIX; i++) send_pix(DS'(i), DS'($urandom), i == 0);
    end_stream();
    tests++;
    if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL s_ready_drop: got %b, required 0", bus.s_ready); end
    run_row(-1, -1);
    for (int k = 0; k < NPIX; k++) idx_win[k*DS +: DS] = DS'(k);
    tests++;
    if (obs_win_l !== idx_win) begin fails++; $display("FAIL first_win_l: got %h, required %h", obs_win_l, idx_win); end
    tests++;
    if (obs_win_r !== model_win(1'b1)) begin
      fails++; $display("FAIL first_win_r: got %h, required %h", obs_win_r, model_win(1'b1));
    end
    check_results("sweep", -1);
    tests++;
    if (bus.err !== 1'b0) begin fails++; $display("FAIL sweep_err: got %b, required 0", bus.err); end
  endtask

  task automatic test_backpressure();
    send_row(1'b0, 1'b0, 0);
    end_stream();
    run_row(2, -1);
    tests++;
    if (obs_hold_bad != 0) begin fails++; $display("FAIL hold_stable: %0d unstable cycles, required 0", obs_hold_bad); end
    tests++;
    if (obs_win_l[DS-1:0] !== DS'(8)) begin fails++; $display("FAIL row9_entry0: got %0d, required 8", obs_win_l[DS-1:0]); end
    tests++;
    if (obs_win_l !== model_win(1'b0) || obs_win_r !== model_win(1'b1)) begin
      fails++; $display("FAIL row9_win: got %h, required %h", obs_win_l, model_win(1'b0));
    end
    check_results("bp", -1);
  endtask

  task automatic test_timeout();
    send_row(1'b0, 1'b0, 0);
    end_stream();
    run_row(-1, 1);
    tests++;
    if (obs_err_lat != TIMEOUT) begin fails++; $display("FAIL err_latency: got %0d, required %0d", obs_err_lat, TIMEOUT); end
    check_results("tmo", 1);
    tests++;
    if (bus.err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b, required 1", bus.err); end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    int seen;
    send_row(1'b0, 1'b0, 0);
    end_stream();
    n = 0;
    while (bus.eng_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    tests++;
    if (n >= BOUND) begin fails++; $display("FAIL rst_setup: eng_ready=%b, required 1", bus.eng_ready); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.s_ready, bus.eng_ready, bus.m_valid, bus.err, bus.eng_rst} !== 5'b00001 ||
        {bus.eng_array_l, bus.eng_array_r} !== '0) begin
      fails++;
      $display("FAIL mid_reset: s_ready/eng_ready/m_valid/err/eng_rst=%b, required 00001; array_l=%h",
               {bus.s_ready, bus.eng_ready, bus.m_valid, bus.err, bus.eng_rst}, bus.eng_array_l);
    end
    hist_zero();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) send_pix(DS'($urandom), DS'($urandom), 1'b0);
    send_row(1'b1, 1'b0, 0);
    send_row(1'b0, 1'b0, 0);
    end_stream();
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.eng_ready === 1'b1 || bus.m_valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 0 || bus.s_ready !== 1'b1) begin
      fails++; $display("FAIL sof_refill: early activity=%0d s_ready=%b, required 0/1", seen, bus.s_ready);
    end
    send_row(1'b0, 1'b0, 0);
    end_stream();
    tests++;
    if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL sof_full: s_ready=%b, required 0", bus.s_ready); end
    run_row(-1, -1);
    tests++;
    if (obs_win_l !== model_win(1'b0) || obs_win_r !== model_win(1'b1)) begin
      fails++; $display("FAIL sof_win: got %h, required %h", obs_win_l, model_win(1'b0));
    end
    check_results("sof", -1);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
    bus.s_pix_l = '0;
    bus.s_pix_r = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_fill_and_sweep();
    test_backpressure();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
